wb_sram_bridge: RTL and testbench

//  Wishbone classic slave on the line-wide bus behind the memory controller's arbiter.

---
 rtl/wb_sram_bridge_pkg.sv | 17 +
 rtl/wb_sram_bridge_beat_timer.sv | 31 +++
 rtl/wb_sram_bridge.sv | 276 +++++++++++++++++++++++++++
 tb/tb_wb_sram_bridge.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_sram_bridge_pkg.sv
// Shared definitions for the Wishbone-to-async-SRAM line bridge:
// FSM state encoding and the wait-state counter width.
package wb_sram_bridge_pkg;

  // Bridge FSM states; the encoding is visible on the debug state port.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ACC   = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_ACK      = 3'd4
  } state_e;

  // Wait states run 0..15, so a 4-bit down-counter covers the range.
  localparam int WS_W = 4;

endpackage

// File: rtl/wb_sram_bridge_beat_timer.sv
// sram_beat_timer: wait-state down-counter shared by read beats and
// write pulses. Loading value_i starts a beat of value_i+1 cycles, and
// done_o is high in the last cycle of that beat.
module sram_beat_timer
  import wb_sram_bridge_pkg::*;
#(
  parameter int W = WS_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  // Load at the start of a beat, otherwise count down and rest at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/wb_sram_bridge.sv
// wb_sram_bridge: Wishbone classic slave that serves each bus line as a
// sequence of SRAM-word beats to an asynchronous SRAM.
// All SRAM strobes and bus outputs are registered from next-state values,
// so they change exactly at the edge where the FSM changes state.
// Optional feature macro: SRAM_BRIDGE_LINEBUF_EN (one-line read buffer).
//
// Handshake: a request is taken in IDLE when wb_stb_i & wb_cyc_i are high.
// wb_ack_o is high for exactly one cycle per completed request. Dropping
// wb_cyc_i mid-request lets the current beat finish and returns to IDLE
// with no acknowledge.
module wb_sram_bridge
  import wb_sram_bridge_pkg::*;
#(
  parameter int WB_DATA_WIDTH    = 128,
  parameter int ADDR_WIDTH       = 32,
  parameter int ADDR_GRANULARITY = 8,
  parameter int SRAM_DATA_WIDTH  = 16,
  parameter int SRAM_ADDR_WIDTH  = 20,
  parameter int WAIT_STATES      = 1
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [ADDR_WIDTH-1:0]                        wb_adr_i,
  input  logic [WB_DATA_WIDTH-1:0]                     wb_dat_i,
  output logic [WB_DATA_WIDTH-1:0]                     wb_dat_o,
  input  logic                                         wb_we_i,
  input  logic [WB_DATA_WIDTH/ADDR_GRANULARITY-1:0]    wb_sel_i,
  input  logic                                         wb_stb_i,
  input  logic                                         wb_cyc_i,
  output logic                                         wb_ack_o,
  output logic                                         wb_err_o,
  output logic                                         wb_rty_o,
  output logic [SRAM_ADDR_WIDTH-1:0]                   sram_addr_o,
  output logic [SRAM_DATA_WIDTH-1:0]                   sram_dq_o,
  input  logic [SRAM_DATA_WIDTH-1:0]                   sram_dq_i,
  output logic                                         sram_dq_oe_o,
  output logic                                         sram_ce_n_o,
  output logic                                         sram_oe_n_o,
  output logic                                         sram_we_n_o,
  output logic [SRAM_DATA_WIDTH/ADDR_GRANULARITY-1:0]  sram_be_n_o,
  output state_e                                       dbg_state_o
);

  localparam int BEATS  = WB_DATA_WIDTH / SRAM_DATA_WIDTH;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int SDW    = SRAM_DATA_WIDTH;
  localparam int LPB    = SRAM_DATA_WIDTH / ADDR_GRANULARITY;  // lanes per beat
  localparam int SEL_W  = WB_DATA_WIDTH / ADDR_GRANULARITY;
  localparam int OFS_W  = $clog2(SEL_W);                        // byte offset in line
  localparam int LINE_W = SRAM_ADDR_WIDTH - BEAT_W;             // SRAM line index

  // One enable bit per beat: a beat is live if any of its byte lanes is set.
  function automatic logic [BEATS-1:0] beat_mask(input logic [SEL_W-1:0] sel);
    logic [BEATS-1:0] m;
    for (int b = 0; b < BEATS; b++) m[b] = |sel[b*LPB +: LPB];
    return m;
  endfunction

  // First enabled beat at or after 'start'; MSB flags whether one exists.
  function automatic logic [BEAT_W:0] find_beat(input logic [BEATS-1:0] mask,
                                                input int start);
    logic [BEAT_W:0] r;
    r = '0;
    for (int b = BEATS - 1; b >= 0; b--) begin
      if (b >= start && mask[b]) r = {1'b1, BEAT_W'(b)};
    end
    return r;
  endfunction

  state_e                     state_q, state_d;
  logic [BEAT_W-1:0]          beat_q, beat_d;
  logic [LINE_W-1:0]          line_q, line_d;
  logic                       we_q, we_d;
  logic [SEL_W-1:0]           sel_q, sel_d;
  logic [WB_DATA_WIDTH-1:0]   wdat_q, wdat_d;
  logic [WB_DATA_WIDTH-1:0]   rdat_q, rdat_d;
  logic                       abort_q, abort_d;
  logic                       abort_now;
  logic [BEAT_W:0]            nb;
  logic                       tmr_load, tmr_done;
  logic [LINE_W-1:0]          req_line;
  logic                       lb_hit, lb_fill, lb_abort, lb_wr_acc;
  logic [WB_DATA_WIDTH-1:0]   lb_data;
  logic                       busy_d, wr_d;

  assign req_line = wb_adr_i[OFS_W +: LINE_W];

  // Address bits below the line and above the SRAM range are don't-care.
  wire unused_adr = ^{wb_adr_i[OFS_W-1:0], wb_adr_i[ADDR_WIDTH-1:OFS_W+LINE_W]};

  sram_beat_timer #(.W(WS_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (tmr_load),
    .value_i (WS_W'(WAIT_STATES)),
    .done_o  (tmr_done)
  );

`ifdef SRAM_BRIDGE_LINEBUF_EN
  logic                     lb_valid_q;
  logic [LINE_W-1:0]        lb_tag_q;
  logic [WB_DATA_WIDTH-1:0] lb_data_q;

  // Line buffer: filled by a completed read, dropped on a write to the line or an abort.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lb_valid_q <= 1'b0;
      lb_tag_q   <= '0;
      lb_data_q  <= '0;
    end else if (lb_fill) begin
      lb_valid_q <= 1'b1;
      lb_tag_q   <= line_q;
      lb_data_q  <= rdat_d;
    end else if (lb_abort || (lb_wr_acc && lb_tag_q == req_line)) begin
      lb_valid_q <= 1'b0;
    end
  end

  assign lb_hit  = lb_valid_q && (lb_tag_q == req_line);
  assign lb_data = lb_data_q;
`else
  assign lb_hit  = 1'b0;
  assign lb_data = '0;
  wire unused_lb = lb_fill ^ lb_abort ^ lb_wr_acc;
`endif

  // Request and beat registers, FSM state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      line_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      abort_q <= abort_d;
    end
  end

  // Next-state logic: acceptance, beat sequencing, abort handling.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    line_d    = line_q;
    we_d      = we_q;
    sel_d     = sel_q;
    wdat_d    = wdat_q;
    rdat_d    = rdat_q;
    abort_now = abort_q | ~wb_cyc_i;
    abort_d   = abort_now;
    tmr_load  = 1'b0;
    lb_fill   = 1'b0;
    lb_abort  = 1'b0;
    lb_wr_acc = 1'b0;
    nb        = '0;
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (wb_stb_i && wb_cyc_i) begin
          line_d = req_line;
          we_d   = wb_we_i;
          sel_d  = wb_sel_i;
          wdat_d = wb_dat_i;
          if (wb_we_i) begin
            lb_wr_acc = 1'b1;
            nb = find_beat(beat_mask(wb_sel_i), 0);
            if (nb[BEAT_W]) begin
              state_d = ST_WR_SETUP;
              beat_d  = nb[BEAT_W-1:0];
            end else begin
              state_d = ST_ACK;
            end
          end else if (lb_hit) begin
            state_d = ST_ACK;
            rdat_d  = lb_data;
          end else begin
            state_d  = ST_RD_ACC;
            beat_d   = '0;
            tmr_load = 1'b1;
          end
        end
      end
      ST_RD_ACC: begin
        if (tmr_done) begin
          rdat_d[beat_q*SDW +: SDW] = sram_dq_i;
          if (abort_now) begin
            state_d  = ST_IDLE;
            lb_abort = 1'b1;
          end else if (beat_q == BEAT_W'(BEATS - 1)) begin
            state_d = ST_ACK;
            lb_fill = 1'b1;
          end else begin
            beat_d   = beat_q + 1'b1;
            tmr_load = 1'b1;
          end
        end
      end
      ST_WR_SETUP: begin
        state_d  = ST_WR_PULSE;
        tmr_load = 1'b1;
      end
      ST_WR_PULSE: begin
        if (tmr_done) begin
          if (abort_now) begin
            state_d  = ST_IDLE;
            lb_abort = 1'b1;
          end else begin
            nb = find_beat(beat_mask(sel_q), int'(beat_q) + 1);
            if (nb[BEAT_W]) begin
              state_d = ST_WR_SETUP;
              beat_d  = nb[BEAT_W-1:0];
            end else begin
              state_d = ST_ACK;
            end
          end
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_d = (state_d == ST_RD_ACC) || (state_d == ST_WR_SETUP) ||
                  (state_d == ST_WR_PULSE);
  assign wr_d   = (state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE);

  // Registered bus and SRAM outputs, derived from the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_ack_o     <= 1'b0;
      wb_dat_o     <= '0;
      sram_ce_n_o  <= 1'b1;
      sram_oe_n_o  <= 1'b1;
      sram_we_n_o  <= 1'b1;
      sram_be_n_o  <= '1;
      sram_dq_oe_o <= 1'b0;
      sram_addr_o  <= '0;
      sram_dq_o    <= '0;
    end else begin
      wb_ack_o     <= (state_d == ST_ACK);
      wb_dat_o     <= (state_d == ST_ACK && !we_d) ? rdat_d : '0;
      sram_ce_n_o  <= ~busy_d;
      sram_oe_n_o  <= (state_d != ST_RD_ACC);
      sram_we_n_o  <= (state_d != ST_WR_PULSE);
      sram_dq_oe_o <= wr_d;
      if (state_d == ST_RD_ACC) begin
        sram_be_n_o <= '0;
      end else if (wr_d) begin
        sram_be_n_o <= ~sel_d[beat_d*LPB +: LPB];
      end else begin
        sram_be_n_o <= '1;
      end
      if (busy_d) sram_addr_o <= {line_d, beat_d};
      if (wr_d)   sram_dq_o   <= wdat_d[beat_d*SDW +: SDW];
    end
  end

  assign wb_err_o    = 1'b0;
  assign wb_rty_o    = 1'b0;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Directed bench for wb_sram_bridge with WAIT_STATES=1 and a behavioural
// async SRAM. SRAM word address of beat b = line index * 8 + b, where the
// line index is byte address >> 4; word k of the SRAM starts as 0x1000+k.
module tb_wb_sram_bridge;
  import wb_sram_bridge_pkg::*;

`ifdef SRAM_BRIDGE_LINEBUF_EN
  localparam int HIT_CYC = 1;
`else
  localparam int HIT_CYC = 17;
`endif

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [31:0]  wb_adr;
  logic [127:0] wb_dat_w, wb_dat_r;
  logic         wb_we, wb_stb, wb_cyc, wb_ack, wb_err, wb_rty;
  logic [15:0]  wb_sel;
  logic [19:0]  sram_addr;
  logic [15:0]  sram_dq_o, sram_dq_i;
  logic         sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [1:0]   sram_be_n;
  state_e       dbg_state;

  wb_sram_bridge dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_adr_i     (wb_adr),
    .wb_dat_i     (wb_dat_w),
    .wb_dat_o     (wb_dat_r),
    .wb_we_i      (wb_we),
    .wb_sel_i     (wb_sel),
    .wb_stb_i     (wb_stb),
    .wb_cyc_i     (wb_cyc),
    .wb_ack_o     (wb_ack),
    .wb_err_o     (wb_err),
    .wb_rty_o     (wb_rty),
    .sram_addr_o  (sram_addr),
    .sram_dq_o    (sram_dq_o),
    .sram_dq_i    (sram_dq_i),
    .sram_dq_oe_o (sram_dq_oe),
    .sram_ce_n_o  (sram_ce_n),
    .sram_oe_n_o  (sram_oe_n),
    .sram_we_n_o  (sram_we_n),
    .sram_be_n_o  (sram_be_n),
    .dbg_state_o  (dbg_state)
  );

  // SRAM model and bus monitor
  logic [15:0] mem [0:511];
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[8:0]] : 16'h0000;

  logic        prev_oe_n = 1'b1;
  logic        prev_we_n = 1'b1;
  logic [19:0] prev_addr = '0;
  int          pulses = 0;
  int          acks = 0;
  int          dq_clash = 0;
  logic [19:0] rd_log[$];
  logic [19:0] wr_log[$];
  logic [1:0]  be_log[$];

  always @(negedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_be_n[0]) mem[sram_addr[8:0]][7:0]  = sram_dq_o[7:0];
      if (!sram_be_n[1]) mem[sram_addr[8:0]][15:8] = sram_dq_o[15:8];
    end
    if (!sram_oe_n && (prev_oe_n || sram_addr != prev_addr)) rd_log.push_back(sram_addr);
    if (!sram_we_n && prev_we_n) begin
      pulses++;
      wr_log.push_back(sram_addr);
      be_log.push_back(sram_be_n);
    end
    if (!sram_oe_n && sram_dq_oe) dq_clash++;
    if (wb_ack) acks++;
    prev_oe_n = sram_oe_n;
    prev_we_n = sram_we_n;
    prev_addr = sram_addr;
  end

  // Scoreboard
  int          compared = 0;
  int          mismatched = 0;
  logic [19:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag, input bit use_wr);
    int n;
    n = use_wr ? wr_log.size() : rd_log.size();
    check({tag, "_len"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check(tag, use_wr ? wr_log[i] : rd_log[i], exp_q[i]);
  endtask

  // Driver: one full request; cycle 0 is the first cycle with stb&cyc high.
  task automatic run_req(input logic we, input logic [31:0] adr, input logic [15:0] sel,
                         input logic [127:0] dat, output int cyc_o, output logic [127:0] rd_o);
    @(posedge clk); #1;
    wb_we = we; wb_adr = adr; wb_sel = sel; wb_dat_w = dat;
    wb_stb = 1'b1; wb_cyc = 1'b1;
    cyc_o = -1;
    rd_o  = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (wb_ack) begin
        cyc_o = c;
        rd_o  = wb_dat_r;
        break;
      end
    end
    @(posedge clk); #1;
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
  endtask

  int           cyc;
  logic [127:0] rdat;
  int           p0, a0;

  initial begin
    for (int k = 0; k < 512; k++) mem[k] = 16'h1000 + 16'(k);
    rst_n = 1'b0;
    wb_adr = '0; wb_dat_w = '0; wb_we = 1'b0; wb_sel = '0; wb_stb = 1'b0; wb_cyc = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", wb_ack, 1'b0);
    check("rst_dat", wb_dat_r, 128'h0);
    check("rst_ce_n", sram_ce_n, 1'b1);
    check("rst_oe_n", sram_oe_n, 1'b1);
    check("rst_we_n", sram_we_n, 1'b1);
    check("rst_be_n", sram_be_n, 2'b11);
    check("rst_dq_oe", sram_dq_oe, 1'b0);
    check("rst_addr", sram_addr, 20'h0);
    check("rst_dq", sram_dq_o, 16'h0);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_err_rty", {wb_err, wb_rty}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full line read of 0x100 -> words 0x80..0x87
    rd_log.delete();
    run_req(1'b0, 32'h0000_0100, 16'h0000, 128'h0, cyc, rdat);
    check("rd_cyc", cyc, 17);
    check("rd_data", rdat, 128'h1087_1086_1085_1084_1083_1082_1081_1080);
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back(20'h80 + 20'(k));
    check_log("rd_addr", 1'b0);

    // Partial write, sel 0x00F0 -> beats 2 and 3 only
    wr_log.delete(); be_log.delete();
    p0 = pulses;
    run_req(1'b1, 32'h0000_0100, 16'h00F0, 128'h1111_2222_3333_4444_DEAD_BEEF_5555_6666, cyc, rdat);
    check("wr2_cyc", cyc, 7);
    check("wr2_dat_o", rdat, 128'h0);
    check("wr2_pulses", pulses - p0, 2);
    exp_q.delete();
    exp_q.push_back(20'h82);
    exp_q.push_back(20'h83);
    check_log("wr2_addr", 1'b1);
    check("wr2_mem82", mem[9'h082], 16'hBEEF);
    check("wr2_mem83", mem[9'h083], 16'hDEAD);
    check("wr2_mem81", mem[9'h081], 16'h1081);
    check("wr2_mem84", mem[9'h084], 16'h1084);

    // Single-lane write, sel 0x0001 at 0x200 -> word 0x100, low byte only
    wr_log.delete(); be_log.delete();
    run_req(1'b1, 32'h0000_0200, 16'h0001, 128'h9999_8888_7777_6666_5555_4444_3333_77CC, cyc, rdat);
    check("wr1_cyc", cyc, 4);
    check("wr1_be_cnt", be_log.size(), 1);
    if (be_log.size() > 0) check("wr1_be_n", be_log[0], 2'b10);
    check("wr1_mem100", mem[9'h100], 16'h11CC);
    check("wr1_mem101", mem[9'h101], 16'h1101);

    // Write with no lanes -> immediate ack, no pulse
    p0 = pulses;
    run_req(1'b1, 32'h0000_0100, 16'h0000, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, cyc, rdat);
    check("wr0_cyc", cyc, 1);
    check("wr0_pulses", pulses - p0, 0);

    // Reset during the second WR_PULSE cycle
    a0 = acks;
    @(posedge clk); #1;
    wb_we = 1'b1; wb_adr = 32'h0000_0300; wb_sel = 16'h000C;
    wb_dat_w = 128'hABCD_ABCD_ABCD_ABCD_ABCD_ABCD_ABCD_ABCD;
    wb_stb = 1'b1; wb_cyc = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rstw_pulse_we_n", sram_we_n, 1'b0);
    check("rstw_pulse_state", dbg_state, ST_WR_PULSE);
    @(negedge clk);
    check("rstw_we_n", sram_we_n, 1'b1);
    check("rstw_ce_n", sram_ce_n, 1'b1);
    check("rstw_dq_oe", sram_dq_oe, 1'b0);
    check("rstw_ack", wb_ack, 1'b0);
    check("rstw_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    rst_n = 1'b1; wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    repeat (3) @(posedge clk);
    check("rstw_no_ack", acks - a0, 0);
    run_req(1'b0, 32'h0000_0100, 16'h0000, 128'h0, cyc, rdat);
    check("rstw_rd_cyc", cyc, 17);
    check("rstw_rd_data", rdat, 128'h1087_1086_1085_1084_DEAD_BEEF_1081_1080);

    // Abort: cyc dropped in the first cycle of read beat 3 (cycle 7)
    a0 = acks;
    rd_log.delete();
    @(posedge clk); #1;
    wb_we = 1'b0; wb_adr = 32'h0000_0100; wb_sel = 16'h0000;
    wb_stb = 1'b1; wb_cyc = 1'b1;
    repeat (7) @(posedge clk);
    #1 wb_stb = 1'b0; wb_cyc = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abt_beat3_state", dbg_state, ST_RD_ACC);
    check("abt_beat3_addr", sram_addr, 20'h83);
    @(negedge clk);
    check("abt_idle_state", dbg_state, ST_IDLE);
    check("abt_idle_ce_n", sram_ce_n, 1'b1);
    repeat (20) @(posedge clk);
    check("abt_no_ack", acks - a0, 0);
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(20'h80 + 20'(k));
    check_log("abt_addr", 1'b0);
    // Next request (aliased address 0x8000_0200 -> word 0x100) in full
    run_req(1'b0, 32'h8000_0200, 16'h0000, 128'h0, cyc, rdat);
    check("abt_next_cyc", cyc, 17);
    check("abt_next_data", rdat, 128'h1107_1106_1105_1104_1103_1102_1101_11CC);

    // Repeated read of one line, then write to it, then read again
    run_req(1'b0, 32'h0000_0100, 16'h0000, 128'h0, cyc, rdat);
    check("lb_first_cyc", cyc, 17);
    run_req(1'b0, 32'h0000_0100, 16'h0000, 128'h0, cyc, rdat);
    check("lb_again_cyc", cyc, HIT_CYC);
    check("lb_again_data", rdat, 128'h1087_1086_1085_1084_DEAD_BEEF_1081_1080);
    run_req(1'b1, 32'h0000_0100, 16'h0003, 128'h0000_0000_0000_0000_0000_0000_0000_5A5A, cyc, rdat);
    check("lb_wr_cyc", cyc, 4);
    run_req(1'b0, 32'h0000_0100, 16'h0000, 128'h0, cyc, rdat);
    check("lb_after_wr_cyc", cyc, 17);
    check("lb_after_wr_data", rdat, 128'h1087_1086_1085_1084_DEAD_BEEF_1081_5A5A);

    check("dq_vs_oe", dq_clash, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
